// File: rtl/dmem_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Optional hit/miss statistics are built only when DCACHE_STATS_EN is defined.
module dmem_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_SETS   = 16
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             cpu_read,
   input  logic                             cpu_write,
   input  logic [ADDR_WIDTH-1:0]            cpu_addr,
   input  logic [DATA_WIDTH-1:0]            cpu_wdata,
   input  logic [1:0]                       cpu_maskmode,
   input  logic                             cpu_sext,
   output logic [DATA_WIDTH-1:0]            cpu_rdata,
   output logic                             cpu_stall,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
   input  logic                             mem_ack,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
   output logic [31:0]                      hit_count,
   output logic [31:0]                      miss_count
);
   localparam int WI     = $clog2(LINE_WORDS);
   localparam int SB     = $clog2(NUM_SETS);
   localparam int OFF    = WI + 2;
   localparam int TAG_W  = ADDR_WIDTH - OFF - SB;
   localparam int LINE_W = LINE_WORDS * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

   state_t                  state_q, state_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic [NUM_SETS-1:0]     valid_q, valid_d;
   logic [NUM_SETS-1:0]     dirty_q, dirty_d;
   logic [TAG_W-1:0]        tag_q [NUM_SETS];
   logic [LINE_W-1:0]       data_q [NUM_SETS];

   logic [SB-1:0]           set_idx;
   logic [TAG_W-1:0]        cpu_tag;
   logic [WI-1:0]           word_idx;
   logic                    req, hit, idle_hit;
   logic [LINE_W-1:0]       cur_line, line_d;
   logic                    line_we, tag_we;
   logic [DATA_WIDTH-1:0]   hit_word, byte_sh, half_sh, load_data;
   logic [DATA_WIDTH-1:0]   wd_rep, merged_word;
   logic [3:0]              be;
   logic [LINE_W-1:0]       merged_line;

   assign set_idx  = cpu_addr[OFF+SB-1:OFF];
   assign cpu_tag  = cpu_addr[ADDR_WIDTH-1:OFF+SB];
   assign word_idx = cpu_addr[OFF-1:2];
   assign req      = cpu_read | cpu_write;
   assign cur_line = data_q[set_idx];
   assign hit      = valid_q[set_idx] && (tag_q[set_idx] == cpu_tag);
   assign idle_hit = (state_q == S_IDLE) && hit;
   assign hit_word = cur_line[word_idx*DATA_WIDTH +: DATA_WIDTH];

   assign cpu_stall = rstn & req & ~idle_hit;
   assign cpu_rdata = (rstn && req && idle_hit) ? load_data : '0;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      byte_sh = hit_word >> {cpu_addr[1:0], 3'b000};
      half_sh = hit_word >> {cpu_addr[1], 4'b0000};
      case (cpu_maskmode)
         2'b00:   load_data = {{(DATA_WIDTH-8){cpu_sext & byte_sh[7]}}, byte_sh[7:0]};
         2'b01:   load_data = {{(DATA_WIDTH-16){cpu_sext & half_sh[15]}}, half_sh[15:0]};
         default: load_data = hit_word;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      case (cpu_maskmode)
         2'b00: begin
            be     = 4'b0001 << cpu_addr[1:0];
            wd_rep = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            be     = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{cpu_wdata[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            wd_rep = cpu_wdata;
         end
      endcase
      for (int b = 0; b < 4; b++) begin
         merged_word[b*8 +: 8] = be[b] ? wd_rep[b*8 +: 8] : hit_word[b*8 +: 8];
      end
      merged_line = cur_line;
      merged_line[word_idx*DATA_WIDTH +: DATA_WIDTH] = merged_word;
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      line_we     = 1'b0;
      tag_we      = 1'b0;
      line_d      = merged_line;
      case (state_q)
         S_IDLE: begin
            if (req && hit) begin
               if (cpu_write) begin
                  line_we          = 1'b1;
                  dirty_d[set_idx] = 1'b1;
               end
            end else if (req) begin
               mem_req_d = 1'b1;
               if (valid_q[set_idx] && dirty_q[set_idx]) begin
                  state_d     = S_WRITEBACK;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tag_q[set_idx], set_idx, {OFF{1'b0}}};
                  mem_wdata_d = cur_line;
               end else begin
                  state_d     = S_REFILL;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {cpu_tag, set_idx, {OFF{1'b0}}};
                  mem_wdata_d = '0;
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ack) begin
               state_d     = S_REFILL;
               mem_we_d    = 1'b0;
               mem_addr_d  = {cpu_tag, set_idx, {OFF{1'b0}}};
               mem_wdata_d = '0;
            end
         end
         S_REFILL: begin
            if (mem_ack) begin
               state_d          = S_IDLE;
               mem_req_d        = 1'b0;
               mem_addr_d       = '0;
               line_we          = 1'b1;
               tag_we           = 1'b1;
               line_d           = mem_rdata;
               valid_d[set_idx] = 1'b1;
               dirty_d[set_idx] = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Line data and tags are qualified by valid, so they are left out of reset.
   always_ff @(posedge clk) begin
      if (rstn && line_we) data_q[set_idx] <= line_d;
      if (rstn && tag_we)  tag_q[set_idx]  <= cpu_tag;
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        fill_done_q, fill_done_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      fill_done_d  = (state_q == S_REFILL) && mem_ack;
      // The first hit after a refill completes the miss; it is not a separate hit.
      if (req && idle_hit && !fill_done_q && hit_count_q != 32'hFFFF_FFFF)
         hit_count_d = hit_count_q + 32'd1;
      if (req && (state_q == S_IDLE) && !hit && miss_count_q != 32'hFFFF_FFFF)
         miss_count_d = miss_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         fill_done_q  <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         fill_done_q  <= fill_done_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif
endmodule
